// File: rtl/shift_seq8_pkg.sv
// Shared opcodes, per-cell mux selects and controller states for the sequenced
// shift register, plus small opcode classification helpers.
package shift_seq8_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op >= OP_LSL) && (op <= OP_ROR);
  endfunction

  // Left-moving ops take each bit from its lower neighbour.
  function automatic logic is_left(input logic [2:0] op);
    return (op == OP_LSL) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_seq8_if.sv
// Command handshake and result bus between the shift register and its user.
interface shift_seq8_if;
  import shift_seq8_pkg::*;

  logic              i_valid;
  logic              o_ready;
  logic [2:0]        i_op;
  logic [2:0]        i_amt;
  logic [DATA_W-1:0] i_d;
  logic [DATA_W-1:0] o_q;
  logic              o_busy;
  logic              o_done;
  logic              o_carry;

  modport master (
    output i_valid, i_op, i_amt, i_d,
    input  o_ready, o_q, o_busy, o_done, o_carry
  );

  modport slave (
    input  i_valid, i_op, i_amt, i_d,
    output o_ready, o_q, o_busy, o_done, o_carry
  );
endinterface

// File: rtl/shift_seq8_cell.sv
// One register bit: a 4-way mux (hold / lower neighbour / upper neighbour / load)
// feeding a synchronously reset flip-flop.
module shift_cell
  import shift_seq8_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       load_in,
  output logic       q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (sel)
      SEL_HOLD:  q_d = q_q;
      SEL_LEFT:  q_d = left_in;
      SEL_RIGHT: q_d = right_in;
      SEL_LOAD:  q_d = load_in;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shift_seq8.sv
// Sequenced universal shift register: a controller steps multi-bit shifts one
// position per clock across a row of shift_cell bits and reports done/carry.
module shift_seq8
  import shift_seq8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  shift_seq8_if.slave   bus
);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               carry_q, carry_d;

  logic [WIDTH-1:0]   q_vec;
  logic [WIDTH-1:0]   load_val;
  logic [1:0]         sel;
  logic               step;
  logic [2:0]         step_op;
  logic               fill_lsb;
  logic               fill_msb;
  logic [WIDTH:0]     left_src;
  logic [WIDTH:0]     right_src;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    carry_d  = carry_q;
    sel      = SEL_HOLD;
    load_val = '0;
    step     = 1'b0;
    step_op  = op_q;
    fill_lsb = 1'b0;
    fill_msb = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          state_d = ST_DONE;
          if (bus.i_op == OP_LOAD) begin
            sel      = SEL_LOAD;
            load_val = bus.i_d;
            carry_d  = 1'b0;
          end else if (bus.i_op == OP_CLR) begin
            sel     = SEL_LOAD;
            carry_d = 1'b0;
          end else if (is_shift(bus.i_op) && (bus.i_amt != 3'd0)) begin
            // First step happens on the accept edge; cnt holds the steps left.
            step    = 1'b1;
            step_op = bus.i_op;
            op_d    = bus.i_op;
            cnt_d   = bus.i_amt - 3'd1;
            if (bus.i_amt != 3'd1) state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        step  = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (step) begin
      if (is_left(step_op)) begin
        sel      = SEL_LEFT;
        carry_d  = q_vec[WIDTH-1];
        fill_lsb = (step_op == OP_ROL) ? q_vec[WIDTH-1] : 1'b0;
      end else begin
        sel      = SEL_RIGHT;
        carry_d  = q_vec[0];
        if (step_op == OP_ASR)      fill_msb = q_vec[WIDTH-1];
        else if (step_op == OP_ROR) fill_msb = q_vec[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      op_q    <= OP_NOP;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      carry_q <= carry_d;
    end
  end

  // Neighbour sources padded with the edge-fill bits so every cell indexes in range.
  assign left_src  = {q_vec, fill_lsb};
  assign right_src = {fill_msb, q_vec};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      shift_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .left_in  (left_src[gi]),
        .right_in (right_src[gi+1]),
        .load_in  (load_val[gi]),
        .q        (q_vec[gi])
      );
    end
  endgenerate

  assign bus.o_q     = q_vec;
  assign bus.o_ready = (state_q == ST_IDLE);
  assign bus.o_busy  = (state_q != ST_IDLE);
  assign bus.o_done  = (state_q == ST_DONE);
  assign bus.o_carry = carry_q;

endmodule

// File: tb/tb_shift_seq8.sv
// Directed scoreboard bench: stimulus queues the hand-computed o_q sequence for
// every busy cycle of a command; a negedge monitor pops and compares.
module tb_shift_seq8;
  import shift_seq8_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shift_seq8_if ifc ();

  shift_seq8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  typedef struct packed {
    logic [7:0] q;
    logic       done;
    logic       carry;
    logic       chk;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] q, input logic done, input logic carry, input logic chk);
    exp_t e;
    e.q = q; e.done = done; e.carry = carry; e.chk = chk;
    exp_q.push_back(e);
  endtask

  // Monitor: every busy cycle must match the next queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      check("busy_vs_ready", {7'd0, ifc.o_busy}, {7'd0, ~ifc.o_ready});
      if (ifc.o_busy) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_busy: q=%h done=%b, nothing expected", ifc.o_q, ifc.o_done);
        end else begin
          e = exp_q.pop_front();
          check("q", ifc.o_q, e.q);
          check("done", {7'd0, ifc.o_done}, {7'd0, e.done});
          if (e.chk) check("carry", {7'd0, ifc.o_carry}, {7'd0, e.carry});
          if (e.done) $display("txn done: q=%h carry=%b", ifc.o_q, ifc.o_carry);
        end
      end else if (ifc.o_done) begin
        total++; bad++;
        $display("FAIL done_while_idle: done=1, required 0");
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ifc.o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.o_ready) begin
      total++; bad++;
      $display("FAIL %s_timeout: o_ready=0 after 50 cycles, required 1", name);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] d);
    wait_ready("issue");
    ifc.i_valid = 1'b1;
    ifc.i_op    = op;
    ifc.i_amt   = amt;
    ifc.i_d     = d;
    @(posedge clk);
    #1;
    ifc.i_valid = 1'b0;
    ifc.i_op    = 3'($urandom);
    ifc.i_amt   = 3'($urandom);
    ifc.i_d     = 8'($urandom);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    ifc.i_valid = 1'b0;
    ifc.i_op    = OP_NOP;
    ifc.i_amt   = 3'd0;
    ifc.i_d     = 8'h00;
    reset       = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_q", ifc.o_q, 8'h00);
    check("rst_carry", {7'd0, ifc.o_carry}, 8'h00);
    check("rst_done", {7'd0, ifc.o_done}, 8'h00);
    check("rst_ready", {7'd0, ifc.o_ready}, 8'h01);
    #1 reset = 1'b0;
    @(negedge clk);

    // 1: LOAD A5
    push(8'hA5, 1'b1, 1'b0, 1'b1);
    issue(OP_LOAD, 3'd0, 8'hA5);
    @(negedge clk);
    check("t1_ready_back", {7'd0, ifc.o_ready}, 8'h01);

    // 2: LSL 3 from A5
    push(8'h4A, 1'b0, 1'b0, 1'b0);
    push(8'h94, 1'b0, 1'b0, 1'b0);
    push(8'h28, 1'b1, 1'b1, 1'b1);
    issue(OP_LSL, 3'd3, 8'h00);

    // 3: LOAD 84, ASR 2, ROR 1
    push(8'h84, 1'b1, 1'b0, 1'b1);
    issue(OP_LOAD, 3'd0, 8'h84);
    push(8'hC2, 1'b0, 1'b0, 1'b0);
    push(8'hE1, 1'b1, 1'b0, 1'b1);
    issue(OP_ASR, 3'd2, 8'h00);
    push(8'hF0, 1'b1, 1'b1, 1'b1);
    issue(OP_ROR, 3'd1, 8'h00);

    // 4: LOAD 01, ROL 7 with CLR held valid throughout
    push(8'h01, 1'b1, 1'b0, 1'b1);
    issue(OP_LOAD, 3'd0, 8'h01);
    push(8'h02, 1'b0, 1'b0, 1'b0);
    push(8'h04, 1'b0, 1'b0, 1'b0);
    push(8'h08, 1'b0, 1'b0, 1'b0);
    push(8'h10, 1'b0, 1'b0, 1'b0);
    push(8'h20, 1'b0, 1'b0, 1'b0);
    push(8'h40, 1'b0, 1'b0, 1'b0);
    push(8'h80, 1'b1, 1'b0, 1'b1);
    push(8'h00, 1'b1, 1'b0, 1'b1);
    wait_ready("t4_rol");
    ifc.i_valid = 1'b1;
    ifc.i_op    = OP_ROL;
    ifc.i_amt   = 3'd7;
    @(posedge clk);
    #1 ifc.i_op = OP_CLR;
    @(negedge clk);
    wait_ready("t4_clr");
    @(posedge clk);
    #1 ifc.i_valid = 1'b0;
    @(negedge clk);

    // 5: LOAD B5, LSR 1 -> 5A carry 1, then LSR 0 and NOP keep both
    push(8'hB5, 1'b1, 1'b0, 1'b1);
    issue(OP_LOAD, 3'd0, 8'hB5);
    push(8'h5A, 1'b1, 1'b1, 1'b1);
    issue(OP_LSR, 3'd1, 8'h00);
    push(8'h5A, 1'b1, 1'b1, 1'b1);
    issue(OP_LSR, 3'd0, 8'h00);
    push(8'h5A, 1'b1, 1'b1, 1'b1);
    issue(OP_NOP, 3'd3, 8'h00);

    // 6: LOAD FF, LSL 7, reset after two steps
    push(8'hFF, 1'b1, 1'b0, 1'b1);
    issue(OP_LOAD, 3'd0, 8'hFF);
    push(8'hFE, 1'b0, 1'b0, 1'b0);
    push(8'hFC, 1'b0, 1'b0, 1'b0);
    issue(OP_LSL, 3'd7, 8'h00);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t6_q", ifc.o_q, 8'h00);
    check("t6_carry", {7'd0, ifc.o_carry}, 8'h00);
    check("t6_done", {7'd0, ifc.o_done}, 8'h00);
    check("t6_ready", {7'd0, ifc.o_ready}, 8'h01);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_done", {7'd0, ifc.o_done}, 8'h00);
    check("queue_empty", 8'(exp_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
